// File: rtl/fp_addsub_normalize_if.sv
// rtl/fp_addsub_normalize_if.sv - operand and result handshake bundle for the add/sub normalise stage
interface fp_addsub_normalize_if #(
    parameter int MW = 28,
    parameter int EW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          SA;
    logic          SB;
    logic          Comp;
    logic [EW-1:0] EO;
    logic [MW-1:0] MA;
    logic [MW-1:0] MB;

    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [MW-1:0] out_mant;
    logic          out_zero;
    logic          out_ovf;

    modport master (
        output in_valid, SA, SB, Comp, EO, MA, MB, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, SA, SB, Comp, EO, MA, MB, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_ovf
    );
endinterface

// File: rtl/fp_addsub_normalize.sv
// rtl/fp_addsub_normalize.sv - mantissa add/subtract with iterative one-bit-per-cycle normalisation
module fp_addsub_normalize #(
    parameter int MW = 28,
    parameter int EW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_addsub_normalize_if.slave  bus
);
    localparam logic [EW-1:0] EXP_MAX = '1;
    localparam logic [EW-1:0] EXP_ONE = EW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ACT_ZERO  = 3'd0,
        ACT_CARRY = 3'd1,
        ACT_HOLD  = 3'd2,
        ACT_SUBN  = 3'd3,
        ACT_SHIFT = 3'd4
    } norm_act_t;

    state_t        state;
    state_t        state_next;
    norm_act_t     norm_act;

    logic          sa_r;
    logic          sb_r;
    logic          comp_r;
    logic [EW-1:0] eo_r;
    logic [MW-1:0] ma_r;
    logic [MW-1:0] mb_r;

    logic          sign_r;
    logic [EW-1:0] exp_r;
    logic [MW-1:0] mant_r;

    logic          res_sign;
    logic [EW-1:0] res_exp;
    logic [MW-1:0] res_mant;
    logic          res_zero;
    logic          res_ovf;

    logic [MW-1:0] carry_mant;
    logic [EW-1:0] carry_exp;
    logic          in_ready_c;
    logic          out_valid_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_next = ADD;
            ADD:  state_next = NORM;
            NORM: if (norm_act != ACT_SHIFT) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state)
            IDLE:    in_ready_c  = 1'b1;
            DONE:    out_valid_c = 1'b1;
            default: ;
        endcase
    end

    // Priority order matters: a carry must be folded back before the hidden bit is trusted.
    always_comb begin
        norm_act = ACT_SHIFT;
        if (mant_r == '0) begin
            norm_act = ACT_ZERO;
        end else if (mant_r[MW-1]) begin
            norm_act = ACT_CARRY;
        end else if (mant_r[MW-2]) begin
            norm_act = ACT_HOLD;
        end else if (exp_r == EXP_ONE) begin
            norm_act = ACT_SUBN;
        end
    end

    // Right shift by one keeps everything shifted out folded into the sticky bit.
    assign carry_mant = {1'b0, mant_r[MW-1:2], mant_r[1] | mant_r[0]};
    assign carry_exp  = exp_r + EXP_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            comp_r   <= 1'b0;
            eo_r     <= '0;
            ma_r     <= '0;
            mb_r     <= '0;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            mant_r   <= '0;
            res_sign <= 1'b0;
            res_exp  <= '0;
            res_mant <= '0;
            res_zero <= 1'b0;
            res_ovf  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa_r   <= bus.SA;
                        sb_r   <= bus.SB;
                        comp_r <= bus.Comp;
                        eo_r   <= bus.EO;
                        ma_r   <= bus.MA;
                        mb_r   <= bus.MB;
                    end
                end
                ADD: begin
                    // MA >= MB is guaranteed upstream, so the difference never wraps.
                    mant_r <= (sa_r == sb_r) ? (ma_r + mb_r) : (ma_r - mb_r);
                    sign_r <= comp_r ? sa_r : sb_r;
                    exp_r  <= eo_r;
                end
                NORM: begin
                    unique case (norm_act)
                        ACT_ZERO: begin
                            res_sign <= 1'b0;
                            res_exp  <= '0;
                            res_mant <= '0;
                            res_zero <= 1'b1;
                            res_ovf  <= 1'b0;
                        end
                        ACT_CARRY: begin
                            res_sign <= sign_r;
                            res_exp  <= carry_exp;
                            res_zero <= 1'b0;
                            if (carry_exp == EXP_MAX) begin
                                res_mant <= '0;
                                res_ovf  <= 1'b1;
                            end else begin
                                res_mant <= carry_mant;
                                res_ovf  <= 1'b0;
                            end
                        end
                        ACT_HOLD: begin
                            res_sign <= sign_r;
                            res_exp  <= exp_r;
                            res_mant <= mant_r;
                            res_zero <= 1'b0;
                            res_ovf  <= 1'b0;
                        end
                        ACT_SUBN: begin
                            res_sign <= sign_r;
                            res_exp  <= '0;
                            res_mant <= mant_r;
                            res_zero <= 1'b0;
                            res_ovf  <= 1'b0;
                        end
                        default: begin
                            mant_r <= {mant_r[MW-2:0], 1'b0};
                            exp_r  <= exp_r - EXP_ONE;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sign  = res_sign;
    assign bus.out_exp   = res_exp;
    assign bus.out_mant  = res_mant;
    assign bus.out_zero  = res_zero;
    assign bus.out_ovf   = res_ovf;
endmodule
